// File: rtl/return_stack.sv
// Return-address stack for the fetch stage.
// On a CALL (push_i) it stores the return address. On a RET (pop_i) it shows
// the most recent address to the PC-select mux in the same cycle as the pop.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en_i         advance enable; push_i/pop_i are ignored while low (stall)
//   push_i       CALL strobe
//   pop_i        RET strobe
//   push_addr_i  return address to store
//   ret_addr_o   top-of-stack entry, 0 when empty (combinational from state)
//   count_o      number of valid entries, 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   ovf_o        sticky: push attempted while full
//   unf_o        sticky: pop attempted while empty
module return_stack #(
   parameter int unsigned AW    = 19,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [AW-1:0] push_addr_i,
   output logic [AW-1:0] ret_addr_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o,
   output logic          ovf_o,
   output logic          unf_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0] mem_q [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic          we;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] top_idx;
   logic          is_empty;
   logic          is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));
   // Only meaningful when not empty; wraps harmlessly otherwise.
   assign top_idx  = PW'(count_q - CW'(1));

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we      = 1'b0;
      wr_idx  = count_q[PW-1:0];
      if (en_i) begin
         case ({push_i, pop_i})
            2'b10: begin
               if (is_full) begin
                  // New address dropped; oldest entries kept.
                  ovf_d = 1'b1;
               end else begin
                  we      = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            2'b01: begin
               if (is_empty) begin
                  unf_d = 1'b1;
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
            2'b11: begin
               if (is_empty) begin
                  // Nothing to pop: behaves as a plain push.
                  we      = 1'b1;
                  count_d = CW'(1);
               end else begin
                  // Replace the top in place; no flag change even when full.
                  we     = 1'b1;
                  wr_idx = top_idx;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage is not reset; it is never visible while empty.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_idx] <= push_addr_i;
      end
   end

   assign ret_addr_o = is_empty ? '0 : mem_q[top_idx];
   assign count_o    = count_q;
   assign empty_o    = is_empty;
   assign full_o     = is_full;
   assign ovf_o      = ovf_q;
   assign unf_o      = unf_q;

endmodule
